system: RTL and testbench

SYSTEM -- requirements
Module: system

---
 rtl/system_pkg.sv | 19 +
 rtl/system_spi_slave.sv | 57 +++++
 rtl/system.sv | 118 +++++++++++
 tb/tb_system.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/system_pkg.sv
// Shared definitions for the single-clock SPI master/slave loopback system.
package system_pkg;

    // Default transfer width and number of slave-select lines.
    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_SS = 4;

    // Bit counter must be able to hold the value DATA_W.
    localparam int DEF_CNT_W = $clog2(DEF_DATA_W + 1);

    // Master transfer sequencing.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } m_state_t;

endpackage

// File: rtl/system_spi_slave.sv
// SPI slave (mode 0, MSB first): shift register, bit counter and receive register.
module spi_slave
    import system_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    // Set when reset hits mid-transfer; silences the slave until deselected.
    logic              aborted_q;

    // Drive MISO only while selected, transmit enabled and not aborted.
    always_comb begin
        miso = 1'b0;
        if (!ss_n && !aborted_q && read) begin
            miso = shift_q[DATA_W-1];
        end
    end

    // Preload while deselected, shift on active sclk, capture once all bits are in.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            data_out  <= '0;
            aborted_q <= !ss_n;
        end else if (ss_n) begin
            shift_q   <= read ? data_in : '0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
        end else if (!aborted_q) begin
            if (sclk) begin
                shift_q <= {shift_q[DATA_W-2:0], mosi};
                cnt_q   <= cnt_q + CNT_W'(1);
            end else if (cnt_q == CNT_W'(DATA_W)) begin
                if (write) begin
                    data_out <= shift_q;
                end
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/system.sv
// SPI master FSM plus one populated slave, connected over an internal bus.
module system
    import system_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_SS = DEF_NUM_SS
) (
    input  logic                      clk,
    input  logic                      s_rst,
    input  logic                      m_rst,
    input  logic                      m_read,
    input  logic                      s_read,
    input  logic                      m_write,
    input  logic                      s_write,
    input  logic [$clog2(NUM_SS)-1:0] slave_sel,
    input  logic [DATA_W-1:0]         m_data_in,
    input  logic [DATA_W-1:0]         s_data_in,
    output logic [DATA_W-1:0]         m_data_out,
    output logic [DATA_W-1:0]         s_data_out_1
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    m_state_t          state_q, state_d;
    logic [DATA_W-1:0] m_shift_q;
    logic [CNT_W-1:0]  m_cnt_q;
    logic [NUM_SS-1:0] ss_n;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              slave1_miso;
    logic [NUM_SS-1:0] miso_lines;

    assign sclk = (state_q == SHIFT);
    assign mosi = m_shift_q[DATA_W-1];

    // Only slave 1 is populated; the other select lines read back zero.
    assign miso_lines = {{(NUM_SS-1){1'b0}}, slave1_miso};

    // Wired-OR of MISO from whichever slave is currently selected.
    always_comb begin
        miso = 1'b0;
        for (int i = 0; i < NUM_SS; i++) begin
            if (!ss_n[i]) begin
                miso = miso | miso_lines[i];
            end
        end
    end

    // Master state register.
    always_ff @(posedge clk) begin
        if (m_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one transfer per request, re-armed only after enables drop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (m_read || m_write) state_d = SHIFT;
            SHIFT: if (m_cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
            DONE:  state_d = HOLD;
            HOLD:  if (!m_read && !m_write) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Master datapath: load at start, shift MISO in, capture and deselect at end.
    always_ff @(posedge clk) begin
        if (m_rst) begin
            m_shift_q  <= '0;
            m_cnt_q    <= '0;
            ss_n       <= '1;
            m_data_out <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m_read || m_write) begin
                        m_shift_q <= m_write ? m_data_in : '0;
                        m_cnt_q   <= '0;
                        ss_n      <= ~(NUM_SS'(1) << slave_sel);
                    end
                end
                SHIFT: begin
                    m_shift_q <= {m_shift_q[DATA_W-2:0], miso};
                    m_cnt_q   <= m_cnt_q + CNT_W'(1);
                end
                DONE: begin
                    if (m_read) begin
                        m_data_out <= m_shift_q;
                    end
                    ss_n <= '1;
                end
                default: ;
            endcase
        end
    end

    spi_slave #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slave1 (
        .clk      (clk),
        .rst      (s_rst),
        .ss_n     (ss_n[0]),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (slave1_miso),
        .read     (s_read),
        .write    (s_write),
        .data_in  (s_data_in),
        .data_out (s_data_out_1)
    );

endmodule

// File: tb/tb_system.sv
// Directed self-checking bench for the SPI loopback system.
module tb_system;

    logic       clk = 1'b0;
    logic       s_rst, m_rst;
    logic       m_read, s_read, m_write, s_write;
    logic [1:0] slave_sel;
    logic [7:0] m_data_in, s_data_in;
    logic [7:0] m_data_out, s_data_out_1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    system #(.DATA_W(8), .NUM_SS(4)) dut (
        .clk          (clk),
        .s_rst        (s_rst),
        .m_rst        (m_rst),
        .m_read       (m_read),
        .s_read       (s_read),
        .m_write      (m_write),
        .s_write      (s_write),
        .slave_sel    (slave_sel),
        .m_data_in    (m_data_in),
        .s_data_in    (s_data_in),
        .m_data_out   (m_data_out),
        .s_data_out_1 (s_data_out_1)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic enables(input logic mr, input logic sr, input logic mw, input logic sw);
        m_read = mr; s_read = sr; m_write = mw; s_write = sw;
    endtask

    initial begin
        s_rst = 1'b1; m_rst = 1'b1;
        enables(0, 0, 0, 0);
        slave_sel = 2'b00; m_data_in = 8'h00; s_data_in = 8'h00;

        // Both resets for one cycle
        tick(1);
        chk("rst_m_data_out", m_data_out, 8'h00);
        chk("rst_s_data_out", s_data_out_1, 8'h00);
        s_rst = 1'b0; m_rst = 1'b0;
        tick(2);

        // Master read of slave 1 (0x57)
        s_data_in = 8'b01010111; enables(1, 1, 0, 0);
        tick(1);                        // k0
        tick(8);                        // k1..k8
        chk("rd_before_k9", m_data_out, 8'h00);
        tick(1);                        // k9
        chk("rd_m_data_out", m_data_out, 8'h57);
        chk("rd_s_data_out", s_data_out_1, 8'h00);
        enables(0, 0, 0, 0);
        tick(2);

        // Master write to slave 1 (0xA5)
        m_data_in = 8'hA5; enables(0, 0, 1, 1);
        tick(9);
        chk("wr_before_k9", s_data_out_1, 8'h00);
        tick(1);
        chk("wr_s_data_out", s_data_out_1, 8'hA5);
        chk("wr_m_hold", m_data_out, 8'h57);
        enables(0, 0, 0, 0);
        tick(2);

        // Full duplex, request held 20 cycles; data changes after k9 must not start a second transfer
        m_data_in = 8'h3C; s_data_in = 8'hC3; enables(1, 1, 1, 1);
        tick(10);
        chk("fd_m_data_out", m_data_out, 8'hC3);
        chk("fd_s_data_out", s_data_out_1, 8'h3C);
        m_data_in = 8'h11; s_data_in = 8'h22;
        tick(10);
        chk("fd_single_m", m_data_out, 8'hC3);
        chk("fd_single_s", s_data_out_1, 8'h3C);
        enables(0, 0, 0, 0);
        tick(2);

        // Unpopulated slave: MISO reads 0, slave 1 does not capture
        slave_sel = 2'b01; s_data_in = 8'hFF; m_data_in = 8'h00; enables(1, 1, 0, 1);
        tick(10);
        chk("unpop_m_data_out", m_data_out, 8'h00);
        chk("unpop_s_data_out", s_data_out_1, 8'h3C);
        enables(0, 0, 0, 0); slave_sel = 2'b00;
        tick(2);

        // Select and master data latched at k0; changes during shift ignored
        s_data_in = 8'h5A; m_data_in = 8'h96; enables(1, 1, 1, 1);
        tick(1);
        slave_sel = 2'b10; m_data_in = 8'h00; s_data_in = 8'h00;
        tick(9);
        chk("latch_m_data_out", m_data_out, 8'h5A);
        chk("latch_s_data_out", s_data_out_1, 8'h96);
        enables(0, 0, 0, 0); slave_sel = 2'b00;
        tick(2);

        // m_rst at k4 of a read aborts everything
        s_data_in = 8'h81; m_data_in = 8'h77; enables(1, 1, 1, 1);
        tick(4);                        // k0..k3
        m_rst = 1'b1; enables(0, 0, 0, 0);
        tick(1);                        // k4
        m_rst = 1'b0;
        chk("mrst_m_data_out", m_data_out, 8'h00);
        chk("mrst_s_data_out", s_data_out_1, 8'h96);
        tick(8);
        chk("mrst_s_no_update", s_data_out_1, 8'h96);
        chk("mrst_m_no_update", m_data_out, 8'h00);
        enables(1, 1, 1, 1);
        tick(10);
        chk("mrst_next_m", m_data_out, 8'h81);
        chk("mrst_next_s", s_data_out_1, 8'h77);
        enables(0, 0, 0, 0);
        tick(2);

        // s_rst at k4: slave goes silent for the remaining bits and does not capture
        s_data_in = 8'hFF; m_data_in = 8'hA5; enables(1, 1, 1, 1);
        tick(4);
        s_rst = 1'b1;
        tick(1);                        // k4
        s_rst = 1'b0;
        chk("srst_s_cleared", s_data_out_1, 8'h00);
        tick(5);                        // k5..k9
        chk("srst_m_data_out", m_data_out, 8'hF0);
        chk("srst_s_no_update", s_data_out_1, 8'h00);
        enables(0, 0, 0, 0);
        tick(2);

        // Both resets override a pending request
        m_data_in = 8'h3C; s_data_in = 8'hC3; enables(1, 1, 1, 1);
        tick(10);
        chk("pre_rst_m", m_data_out, 8'hC3);
        s_rst = 1'b1; m_rst = 1'b1;
        tick(1);
        chk("both_rst_m", m_data_out, 8'h00);
        chk("both_rst_s", s_data_out_1, 8'h00);
        s_rst = 1'b0; m_rst = 1'b0; enables(0, 0, 0, 0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
